// File: rtl/butterfly_ntt_ctrl.sv
// Sequencer for one dual-mode butterfly over an in-place Kyber NTT/INTT.
// Ports: start/inv/busy/done handshake; rd_*/tw_addr issue; wr_* delayed write-back.
module butterfly_ntt_ctrl #(
   parameter int LOGN   = 8,
   parameter int BF_LAT = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            inv,
   output logic            busy,
   output logic            done,
   output logic            ct,
   output logic            rd_en,
   output logic [LOGN-1:0] rd_addr_a,
   output logic [LOGN-1:0] rd_addr_b,
   output logic [LOGN-2:0] tw_addr,
   output logic            wr_en,
   output logic [LOGN-1:0] wr_addr_a,
   output logic [LOGN-1:0] wr_addr_b
);

   localparam int KW = LOGN - 1;
   localparam logic [LOGN-1:0] ONE        = LOGN'(1);
   localparam logic [LOGN-1:0] TWO        = LOGN'(2);
   localparam logic [LOGN-1:0] HALF       = LOGN'(1 << (LOGN - 1));
   localparam logic [LOGN-1:0] LAST_BF    = HALF - ONE;
   localparam logic [LOGN-1:0] LAST_STAGE = LOGN'(LOGN - 2);
   localparam logic [KW-1:0]   K_ONE      = KW'(1);
   localparam logic [KW-1:0]   K_TOP      = '1;
   localparam logic [3:0]      DRAIN_LAST = 4'(BF_LAT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN,
      S_DONE
   } state_e;

   state_e state_q, state_d;
   logic ct_q, ct_d;
   logic [LOGN-1:0] len_q, len_d;
   logic [LOGN-1:0] base_q, base_d;
   logic [LOGN-1:0] j_q, j_d;
   logic [LOGN-1:0] bf_q, bf_d;
   logic [LOGN-1:0] stage_q, stage_d;
   logic [KW-1:0] k_q, k_d;
   logic [3:0] dcnt_q, dcnt_d;
   logic [BF_LAT-1:0] wen_q, wen_d;
   logic [BF_LAT-1:0][LOGN-1:0] wa_q, wa_d;
   logic [BF_LAT-1:0][LOGN-1:0] wb_q, wb_d;

   logic grp_end;
   logic stage_end;
   logic last_stage;

   assign rd_en     = (state_q == S_ISSUE);
   assign busy      = (state_q == S_ISSUE) || (state_q == S_DRAIN);
   assign done      = (state_q == S_DONE);
   assign ct        = ct_q;
   assign rd_addr_a = j_q;
   assign rd_addr_b = j_q + len_q;
   assign tw_addr   = k_q;
   assign wr_en     = wen_q[BF_LAT-1];
   assign wr_addr_a = wa_q[BF_LAT-1];
   assign wr_addr_b = wb_q[BF_LAT-1];

   assign grp_end    = (j_q == base_q + len_q - ONE);
   assign stage_end  = (bf_q == LAST_BF);
   assign last_stage = (stage_q == LAST_STAGE);

   always_comb begin
      state_d = state_q;
      ct_d    = ct_q;
      len_d   = len_q;
      base_d  = base_q;
      j_d     = j_q;
      bf_d    = bf_q;
      stage_d = stage_q;
      k_d     = k_q;
      dcnt_d  = dcnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_ISSUE;
               ct_d    = ~inv;
               len_d   = inv ? TWO : HALF;
               k_d     = inv ? K_TOP : K_ONE;
               base_d  = '0;
               j_d     = '0;
               bf_d    = '0;
               stage_d = '0;
            end
         end
         S_ISSUE: begin
            bf_d = bf_q + ONE;
            j_d  = j_q + ONE;
            if (grp_end) begin
               base_d = base_q + (len_q << 1);
               j_d    = base_q + (len_q << 1);
               // the final group has no successor; keep k inside 1..N/2-1
               if (!(stage_end && last_stage))
                  k_d = ct_q ? k_q + K_ONE : k_q - K_ONE;
            end
            if (stage_end) begin
               state_d = S_DRAIN;
               dcnt_d  = '0;
               bf_d    = '0;
               base_d  = '0;
               j_d     = '0;
               len_d   = ct_q ? (len_q >> 1) : (len_q << 1);
            end
         end
         S_DRAIN: begin
            dcnt_d = dcnt_q + 4'd1;
            if (dcnt_q == DRAIN_LAST) begin
               if (last_stage) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_ISSUE;
                  stage_d = stage_q + ONE;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // write-back delay line: wr_* is rd_* exactly BF_LAT cycles later
   always_comb begin
      wen_d    = wen_q;
      wa_d     = wa_q;
      wb_d     = wb_q;
      wen_d[0] = rd_en;
      wa_d[0]  = rd_addr_a;
      wb_d[0]  = rd_addr_b;
      for (int i = 1; i < BF_LAT; i++) begin
         wen_d[i] = wen_q[i-1];
         wa_d[i]  = wa_q[i-1];
         wb_d[i]  = wb_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         ct_q    <= 1'b1;
         len_q   <= '0;
         base_q  <= '0;
         j_q     <= '0;
         bf_q    <= '0;
         stage_q <= '0;
         k_q     <= '0;
         dcnt_q  <= '0;
         wen_q   <= '0;
         wa_q    <= '0;
         wb_q    <= '0;
      end else begin
         state_q <= state_d;
         ct_q    <= ct_d;
         len_q   <= len_d;
         base_q  <= base_d;
         j_q     <= j_d;
         bf_q    <= bf_d;
         stage_q <= stage_d;
         k_q     <= k_d;
         dcnt_q  <= dcnt_d;
         wen_q   <= wen_d;
         wa_q    <= wa_d;
         wb_q    <= wb_d;
      end
   end

endmodule

// File: tb/tb_butterfly_ntt_ctrl.sv
// Scoreboard bench for butterfly_ntt_ctrl (BF_LAT=4 main, BF_LAT=1 side build).
// Stimulus pushes expected rd/wr/done events; a negedge monitor pops and compares.
module tb_butterfly_ntt_ctrl;

   localparam int LOGN = 8;
   localparam int N    = 256;
   localparam int L    = 4;

   typedef struct {
      int cyc;
      int a;
      int b;
      int k;
      bit ct;
   } ev_t;

   ev_t rdq[$];
   ev_t wrq[$];
   int  doneq[$];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic clk = 1'b0;
   logic rst, start, inv;
   logic busy, done, ct, rd_en, wr_en;
   logic [LOGN-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
   logic [LOGN-2:0] tw_addr;

   logic start1;
   logic busy1, done1, ct1, rd_en1, wr_en1;
   logic [LOGN-1:0] rd_a1, rd_b1, wr_a1, wr_b1;
   logic [LOGN-2:0] tw1;

   butterfly_ntt_ctrl #(.LOGN(LOGN), .BF_LAT(L)) u_dut (
      .clk(clk), .rst(rst), .start(start), .inv(inv),
      .busy(busy), .done(done), .ct(ct), .rd_en(rd_en),
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
      .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
   );

   butterfly_ntt_ctrl #(.LOGN(LOGN), .BF_LAT(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .inv(1'b0),
      .busy(busy1), .done(done1), .ct(ct1), .rd_en(rd_en1),
      .rd_addr_a(rd_a1), .rd_addr_b(rd_b1), .tw_addr(tw1),
      .wr_en(wr_en1), .wr_addr_a(wr_a1), .wr_addr_b(wr_b1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   // reference loop nest: expected reads, write-backs and done cycle
   task automatic push_run(input int t0, input bit iv);
      int c;
      int len;
      int k;
      ev_t e;
      c   = t0 + 1;
      len = iv ? 2 : N / 2;
      k   = iv ? N / 2 - 1 : 1;
      for (int s = 0; s < LOGN - 1; s++) begin
         for (int st = 0; st < N; st += 2 * len) begin
            for (int j = st; j < st + len; j++) begin
               e.cyc = c; e.a = j; e.b = j + len; e.k = k; e.ct = !iv;
               rdq.push_back(e);
               e.cyc = c + L;
               wrq.push_back(e);
               c++;
            end
            k = iv ? k - 1 : k + 1;
         end
         c += L;
         len = iv ? len * 2 : len / 2;
      end
      doneq.push_back(t0 + (LOGN - 1) * (N / 2 + L) + 1);
   endtask

   task automatic trim(input int lim);
      while (rdq.size() > 0 && rdq[$].cyc > lim) void'(rdq.pop_back());
      while (wrq.size() > 0 && wrq[$].cyc > lim) void'(wrq.pop_back());
      while (doneq.size() > 0 && doneq[$] > lim) void'(doneq.pop_back());
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   // main monitor
   ev_t me;
   int  md;
   always @(negedge clk) begin
      if (rd_en) begin
         checks++;
         if (rdq.size() == 0) begin
            failures++;
            $display("FAIL rd_unexpected cyc=%0d a=%0d b=%0d", cyc,
                     rd_addr_a, rd_addr_b);
         end else begin
            me = rdq.pop_front();
            if (cyc != me.cyc || rd_addr_a != me.a || rd_addr_b != me.b
                || tw_addr != me.k || ct != me.ct) begin
               failures++;
               $display("FAIL rd actual cyc=%0d a=%0d b=%0d k=%0d ct=%0d required cyc=%0d a=%0d b=%0d k=%0d ct=%0d",
                        cyc, rd_addr_a, rd_addr_b, tw_addr, ct,
                        me.cyc, me.a, me.b, me.k, me.ct);
            end
         end
      end else if (rdq.size() > 0 && rdq[0].cyc <= cyc) begin
         checks++;
         failures++;
         me = rdq.pop_front();
         $display("FAIL rd_missing cyc=%0d required a=%0d b=%0d at %0d",
                  cyc, me.a, me.b, me.cyc);
      end
      if (wr_en) begin
         checks++;
         if (wrq.size() == 0) begin
            failures++;
            $display("FAIL wr_unexpected cyc=%0d a=%0d b=%0d", cyc,
                     wr_addr_a, wr_addr_b);
         end else begin
            me = wrq.pop_front();
            if (cyc != me.cyc || wr_addr_a != me.a || wr_addr_b != me.b) begin
               failures++;
               $display("FAIL wr actual cyc=%0d a=%0d b=%0d required cyc=%0d a=%0d b=%0d",
                        cyc, wr_addr_a, wr_addr_b, me.cyc, me.a, me.b);
            end
         end
      end else if (wrq.size() > 0 && wrq[0].cyc <= cyc) begin
         checks++;
         failures++;
         me = wrq.pop_front();
         $display("FAIL wr_missing cyc=%0d required a=%0d b=%0d at %0d",
                  cyc, me.a, me.b, me.cyc);
      end
      if (done) begin
         checks++;
         if (doneq.size() == 0) begin
            failures++;
            $display("FAIL done_unexpected cyc=%0d", cyc);
         end else begin
            md = doneq.pop_front();
            if (cyc != md || busy !== 1'b0) begin
               failures++;
               $display("FAIL done actual cyc=%0d busy=%0d required cyc=%0d busy=0",
                        cyc, busy, md);
            end
         end
      end else if (doneq.size() > 0 && doneq[0] <= cyc) begin
         checks++;
         failures++;
         md = doneq.pop_front();
         $display("FAIL done_missing cyc=%0d required %0d", cyc, md);
      end
   end

   // BF_LAT=1 side build: one-cycle write lag and done at 904
   int  t1 = -1;
   int  rdcnt1 = 0;
   bit  done1_seen = 1'b0;
   logic            p_en = 1'b0;
   logic [LOGN-1:0] p_a = '0;
   logic [LOGN-1:0] p_b = '0;
   always @(negedge clk) begin
      if (rd_en1) rdcnt1++;
      if (wr_en1 || p_en) begin
         checks++;
         if (wr_en1 !== p_en || (p_en && (wr_a1 !== p_a || wr_b1 !== p_b))) begin
            failures++;
            $display("FAIL lat1_wr cyc=%0d actual en=%0d a=%0d b=%0d required en=%0d a=%0d b=%0d",
                     cyc, wr_en1, wr_a1, wr_b1, p_en, p_a, p_b);
         end
      end
      if (done1) begin
         done1_seen = 1'b1;
         checks++;
         if (cyc != t1 + 904 || rdcnt1 != 896) begin
            failures++;
            $display("FAIL lat1_done actual cyc=%0d reads=%0d required cyc=%0d reads=896",
                     cyc, rdcnt1, t1 + 904);
         end
      end
      p_en <= rd_en1;
      p_a  <= rd_a1;
      p_b  <= rd_b1;
   end

   int t0;
   initial begin
      rst = 1'b0; start = 1'b0; inv = 1'b0; start1 = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ct", ct, 1);
      chk("rst_rd_en", rd_en, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_rd_addr_a", rd_addr_a, 0);
      chk("rst_tw_addr", tw_addr, 0);
      chk("rst_wr_addr_b", wr_addr_b, 0);
      rst = 1'b1;
      @(negedge clk);

      // NTT on both builds
      t0 = cyc; t1 = cyc;
      start = 1'b1; inv = 1'b0; start1 = 1'b1;
      push_run(t0, 1'b0);
      @(negedge clk);
      start = 1'b0; start1 = 1'b0;
      wait_cyc(t0 + 5);
      chk("busy_run", busy, 1);

      // start held through DONE (ignored) into IDLE (accepted), INTT
      wait_cyc(t0 + 925);
      start = 1'b1; inv = 1'b1;
      @(negedge clk);
      t0 = cyc;
      push_run(t0, 1'b1);
      @(negedge clk);
      start = 1'b0; inv = 1'b0;

      // NTT with a stray start mid-run
      wait_cyc(t0 + 926);
      t0 = cyc;
      start = 1'b1;
      push_run(t0, 1'b0);
      @(negedge clk);
      start = 1'b0;
      wait_cyc(t0 + 50);
      start = 1'b1; inv = 1'b1;
      @(negedge clk);
      start = 1'b0; inv = 1'b0;

      // reset mid-run, then a fresh NTT
      wait_cyc(t0 + 927);
      t0 = cyc;
      start = 1'b1;
      push_run(t0, 1'b0);
      @(negedge clk);
      start = 1'b0;
      wait_cyc(t0 + 300);
      rst = 1'b0;
      trim(t0 + 300);
      @(negedge clk);
      rst = 1'b1;
      chk("abort_busy", busy, 0);
      chk("abort_rd_en", rd_en, 0);
      chk("abort_wr_en", wr_en, 0);
      chk("abort_done", done, 0);
      chk("abort_ct", ct, 1);
      @(negedge clk);
      t0 = cyc;
      start = 1'b1;
      push_run(t0, 1'b0);
      @(negedge clk);
      start = 1'b0;
      wait_cyc(t0 + 930);

      chk("rd_left", rdq.size(), 0);
      chk("wr_left", wrq.size(), 0);
      chk("done_left", doneq.size(), 0);
      chk("lat1_done_seen", done1_seen, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
